// File: rtl/dac714_pkg.sv
// Shared definitions for the DAC714 serial transmitter: FSM encoding and default timing.
package dac714_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_GAP   = 2'd3
  } dac_state_t;

  localparam int DEF_SCLK_DIV     = 2;
  localparam int DEF_LATCH_CYCLES = 2;
  localparam int DEF_GAP_CYCLES   = 1;

endpackage

// File: rtl/dac714_sclk_div.sv
// Half-period counter for the DAC serial clock: reports the high phase and the
// last cycle of each bit while the shifter is running.
module dac714_sclk_div #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk_slow,
  input  logic nReset,
  input  logic i_run,
  output logic o_phase_high,
  output logic o_bit_done
);

  localparam int CW = (2 * SCLK_DIV > 2) ? $clog2(2 * SCLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(2 * SCLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(SCLK_DIV);

  logic [CW-1:0] r_cnt;

  // Held at zero while idle so every frame starts at the beginning of a low phase.
  always_ff @(posedge clk_slow) begin
    if (!nReset || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_phase_high = (r_cnt >= HALF);
  assign o_bit_done   = i_run && (r_cnt == LAST);

endmodule

// File: rtl/dac714_serial_tx.sv
// DAC714 serial transmitter: captures a sample on each DACStrobe rising edge,
// shifts it MSB-first, pulses the load strobe, and keeps one pending sample.
module dac714_serial_tx
  import dac714_pkg::*;
#(
  parameter int DAC_WIDTH     = 16,
  parameter int SCLK_DIV      = DEF_SCLK_DIV,
  parameter int LATCH_CYCLES  = DEF_LATCH_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter bit OFFSET_BINARY = 1'b0
) (
  input  logic                        clk_slow,
  input  logic                        nReset,
  input  logic                        DACStrobe,
  input  logic signed [DAC_WIDTH-1:0] Yis,
  input  logic                        clr_overrun,
  output logic                        dac_sdi,
  output logic                        dac_sclk,
  output logic                        dac_nlatch,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  overrun_cnt
);

  localparam int TMAX = (LATCH_CYCLES > GAP_CYCLES) ? LATCH_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (DAC_WIDTH > 2) ? $clog2(DAC_WIDTH) : 1;
  localparam logic [DAC_WIDTH-1:0] MSB_MASK = {1'b1, {(DAC_WIDTH-1){1'b0}}};

  dac_state_t           r_state, w_next;
  logic                 r_strobe_d;
  logic [DAC_WIDTH-1:0] r_shreg;
  logic [BW-1:0]        r_bitcnt;
  logic [DAC_WIDTH-1:0] r_buf;
  logic                 r_buf_full;
  logic [TW-1:0]        r_tcnt;
  logic [7:0]           r_ovr;

  logic                 w_ev, w_ovw, w_direct;
  logic                 w_run, w_phase_high, w_bit_done;
  logic                 w_latch_end, w_frame_end;
  logic                 w_load_ev, w_load_buf;
  logic [DAC_WIDTH-1:0] w_sample;

  assign w_ev     = DACStrobe & ~r_strobe_d;
  assign w_ovw    = w_ev & r_buf_full;
  assign w_sample = Yis ^ (OFFSET_BINARY ? MSB_MASK : '0);
  assign w_run    = (r_state == ST_SHIFT);

  assign w_latch_end = (r_state == ST_LATCH) && (r_tcnt == TW'(LATCH_CYCLES - 1));
  // Without a gap the end of the latch pulse doubles as the end of the frame.
  assign w_frame_end = (GAP_CYCLES > 0) ? ((r_state == ST_GAP) && (r_tcnt == TW'(GAP_CYCLES - 1)))
                                        : w_latch_end;
  assign w_direct    = (r_state == ST_IDLE) | w_frame_end;

  dac714_sclk_div #(.SCLK_DIV(SCLK_DIV)) u_sclk_div (
    .clk_slow     (clk_slow),
    .nReset       (nReset),
    .i_run        (w_run),
    .o_phase_high (w_phase_high),
    .o_bit_done   (w_bit_done)
  );

  always_comb begin
    w_next     = r_state;
    w_load_ev  = 1'b0;
    w_load_buf = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ev) begin
          w_next    = ST_SHIFT;
          w_load_ev = 1'b1;
        end else if (r_buf_full) begin
          w_next     = ST_SHIFT;
          w_load_buf = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_bit_done && (r_bitcnt == '0)) w_next = ST_LATCH;
      end
      ST_LATCH: begin
        if (w_latch_end && (GAP_CYCLES > 0)) w_next = ST_GAP;
      end
      default: ;
    endcase
    if (w_frame_end) begin
      if (w_ev) begin
        w_next    = ST_SHIFT;
        w_load_ev = 1'b1;
      end else if (r_buf_full) begin
        w_next     = ST_SHIFT;
        w_load_buf = 1'b1;
      end else begin
        w_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_slow) begin
    if (!nReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_slow) begin
    if (!nReset) begin
      r_strobe_d <= 1'b0;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_tcnt     <= '0;
      r_ovr      <= '0;
    end else begin
      r_strobe_d <= DACStrobe;

      // The final bit is not shifted out so sdi keeps it during the latch pulse.
      if (w_load_ev) begin
        r_shreg  <= w_sample;
        r_bitcnt <= BW'(DAC_WIDTH - 1);
      end else if (w_load_buf) begin
        r_shreg  <= r_buf;
        r_bitcnt <= BW'(DAC_WIDTH - 1);
      end else if (w_run && w_bit_done && (r_bitcnt != '0)) begin
        r_shreg  <= {r_shreg[DAC_WIDTH-2:0], 1'b0};
        r_bitcnt <= r_bitcnt - BW'(1);
      end

      if (w_ev) begin
        if (!w_direct) r_buf <= w_sample;
        r_buf_full <= !w_direct;
      end else if (w_load_buf) begin
        r_buf_full <= 1'b0;
      end

      if (w_next != r_state) begin
        r_tcnt <= '0;
      end else if ((r_state == ST_LATCH) || (r_state == ST_GAP)) begin
        r_tcnt <= r_tcnt + TW'(1);
      end

      if (clr_overrun) begin
        r_ovr <= w_ovw ? 8'd1 : '0;
      end else if (w_ovw && (r_ovr != '1)) begin
        r_ovr <= r_ovr + 8'd1;
      end
    end
  end

  assign dac_sclk    = w_run & w_phase_high;
  assign dac_sdi     = ((r_state == ST_SHIFT) || (r_state == ST_LATCH)) ? r_shreg[DAC_WIDTH-1] : 1'b0;
  assign dac_nlatch  = (r_state != ST_LATCH);
  assign busy        = (r_state != ST_IDLE) | r_buf_full;
  assign done        = (GAP_CYCLES > 0) ? ((r_state == ST_GAP) && (r_tcnt == '0)) : w_latch_end;
  assign overrun_cnt = r_ovr;

endmodule
